serial_subtractor: RTL and testbench

- Bit-serial two's-complement subtractor computing diff = a - b, LSB first, one bit per clock.
- Uses a single borrow flip-flop and a start/busy/done handshake.
- Trades WIDTH cycles of latency for one full-subtractor cell. It is the inverse-direction counterpart to the team's combinational ripple adder.
- Used in area-constrained datapaths where a subtract result can wait WIDTH+1 cycles.

---
 rtl/serial_subtractor.sv | 137 +++++++++++++
 tb/tb_serial_subtractor.sv | 330 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/serial_subtractor.sv
// Bit-serial two's-complement subtractor: diff = a - b, LSB first, one bit per clock.
// A single full-subtractor cell and one borrow flop are reused WIDTH times.
//
// Ports:
//   clk    rising-edge clock
//   rst    asynchronous, active-high reset
//   start  operation request, sampled only while idle
//   a, b   minuend / subtrahend, captured when start is accepted
//   diff   registered result (a - b) mod 2^WIDTH
//   bout   final borrow, 1 iff a < b (unsigned)
//   zero   1 iff diff == 0, registered together with diff
//   busy   1 while an operation is in flight (SHIFT or DONE)
//   done   one-cycle pulse when diff/bout/zero have just been updated
module serial_subtractor #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] diff,
  output logic             bout,
  output logic             zero,
  output logic             busy,
  output logic             done
);

  localparam int unsigned     CntW    = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(WIDTH - 1);

  typedef enum logic [1:0] {
    StIdle,
    StShift,
    StDone
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_sr_q, a_sr_d;
  logic [WIDTH-1:0] b_sr_q, b_sr_d;
  logic [WIDTH-1:0] r_sr_q, r_sr_d;
  logic             borrow_q, borrow_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic [WIDTH-1:0] diff_q, diff_d;
  logic             bout_q, bout_d;
  logic             zero_q, zero_d;

  // Full-subtractor cell on the current LSBs.
  logic             bit_a, bit_b, bit_d, borrow_nx;
  logic [WIDTH-1:0] r_nx;

  always_comb begin
    bit_a     = a_sr_q[0];
    bit_b     = b_sr_q[0];
    bit_d     = bit_a ^ bit_b ^ borrow_q;
    borrow_nx = (~bit_a & bit_b) | (~(bit_a ^ bit_b) & borrow_q);
    // Result bits enter at the MSB so that after WIDTH shifts bit 0 sits at the LSB.
    r_nx      = {bit_d, r_sr_q[WIDTH-1:1]};
  end

  always_comb begin
    state_d  = state_q;
    a_sr_d   = a_sr_q;
    b_sr_d   = b_sr_q;
    r_sr_d   = r_sr_q;
    borrow_d = borrow_q;
    cnt_d    = cnt_q;
    diff_d   = diff_q;
    bout_d   = bout_q;
    zero_d   = zero_q;

    unique case (state_q)
      StIdle: begin
        if (start) begin
          a_sr_d   = a;
          b_sr_d   = b;
          borrow_d = 1'b0;
          cnt_d    = '0;
          state_d  = StShift;
        end
      end
      StShift: begin
        a_sr_d   = a_sr_q >> 1;
        b_sr_d   = b_sr_q >> 1;
        r_sr_d   = r_nx;
        borrow_d = borrow_nx;
        if (cnt_q == CntLast) begin
          // Last bit: publish the complete result, including the bit computed now.
          diff_d  = r_nx;
          bout_d  = borrow_nx;
          zero_d  = (r_nx == '0);
          state_d = StDone;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= StIdle;
      a_sr_q   <= '0;
      b_sr_q   <= '0;
      r_sr_q   <= '0;
      borrow_q <= 1'b0;
      cnt_q    <= '0;
      diff_q   <= '0;
      bout_q   <= 1'b0;
      zero_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      a_sr_q   <= a_sr_d;
      b_sr_q   <= b_sr_d;
      r_sr_q   <= r_sr_d;
      borrow_q <= borrow_d;
      cnt_q    <= cnt_d;
      diff_q   <= diff_d;
      bout_q   <= bout_d;
      zero_q   <= zero_d;
    end
  end

  assign diff = diff_q;
  assign bout = bout_q;
  assign zero = zero_q;
  // DONE lasts exactly one cycle, so the pulse is a state decode.
  assign busy = (state_q != StIdle);
  assign done = (state_q == StDone);

endmodule

// File: tb/tb_serial_subtractor.sv
// Self-checking bench for serial_subtractor (WIDTH = 8).
module tb_serial_subtractor;

  localparam int W = 8;

  logic         clk;
  logic         rst;
  logic         start;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic [W-1:0] diff;
  logic         bout;
  logic         zero;
  logic         busy;
  logic         done;

  int checks;
  int failures;

  // Expected {bout, diff} per accepted operation, in acceptance order.
  logic [W:0] exp_q[$];

  serial_subtractor #(
    .WIDTH(W)
  ) dut (
    .clk  (clk),
    .rst  (rst),
    .start(start),
    .a    (a),
    .b    (b),
    .diff (diff),
    .bout (bout),
    .zero (zero),
    .busy (busy),
    .done (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [W:0] ref_sub(input logic [W-1:0] x, input logic [W-1:0] y);
    return {1'b0, x} - {1'b0, y};
  endfunction

  // Issues one op from a negedge and watches W+3 cycles; returns observations only.
  task automatic do_op(input logic [W-1:0] ia, input logic [W-1:0] ib,
                       output int done_cyc, output int done_cnt, output int busy_cnt,
                       output logic [W-1:0] diff_c1);
    start = 1'b1;
    a     = ia;
    b     = ib;
    exp_q.push_back(ref_sub(ia, ib));
    @(posedge clk);
    #1;
    start = 1'b0;
    a     = W'($urandom);
    b     = W'($urandom);
    done_cyc = 0;
    done_cnt = 0;
    busy_cnt = 0;
    diff_c1  = '0;
    for (int c = 1; c <= W + 3; c++) begin
      @(negedge clk);
      if (busy) busy_cnt++;
      if (done) begin
        done_cnt++;
        done_cyc = c;
      end
      if (c == 1) diff_c1 = diff;
    end
  endtask

  task automatic test_reset;
    rst   = 1'b1;
    start = 1'b1;
    a     = 8'h12;
    b     = 8'h34;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({diff, bout, zero, busy, done} !== '0) begin
      failures++;
      $display("FAIL reset_state: got diff=%h bout=%b zero=%b busy=%b done=%b, want all 0",
               diff, bout, zero, busy, done);
    end
    rst   = 1'b0;
    start = 1'b0;
    @(negedge clk);
    checks++;
    if (busy !== 1'b0) begin
      failures++;
      $display("FAIL start_during_reset: busy=%b want 0", busy);
    end
  endtask

  task automatic test_basic;
    int dc, dn, bc;
    logic [W-1:0] d1;
    logic [W:0]   e;
    do_op(8'h5A, 8'h23, dc, dn, bc, d1);
    e = exp_q.pop_front();
    checks++;
    if (bc != W + 1) begin
      failures++;
      $display("FAIL basic_busy_cycles: got %0d want %0d", bc, W + 1);
    end
    checks++;
    if (dn != 1 || dc != W + 1) begin
      failures++;
      $display("FAIL basic_done_timing: got count=%0d cycle=%0d want count=1 cycle=%0d",
               dn, dc, W + 1);
    end
    checks++;
    if ({bout, diff} !== e || e !== 9'h037) begin
      failures++;
      $display("FAIL basic_result: got bout=%b diff=%h want bout=0 diff=37", bout, diff);
    end
    checks++;
    if (zero !== 1'b0) begin
      failures++;
      $display("FAIL basic_zero: got %b want 0", zero);
    end
  endtask

  task automatic test_values;
    logic [W-1:0] va[4] = '{8'h10, 8'h00, 8'hFF, 8'h00};
    logic [W-1:0] vb[4] = '{8'h20, 8'h00, 8'h01, 8'hFF};
    logic [W-1:0] prev_diff;
    int dc, dn, bc;
    logic [W-1:0] d1;
    logic [W:0]   e;
    prev_diff = 8'h37;
    for (int i = 0; i < 4; i++) begin
      do_op(va[i], vb[i], dc, dn, bc, d1);
      e = exp_q.pop_front();
      checks++;
      if (d1 !== prev_diff) begin
        failures++;
        $display("FAIL values_hold[%0d]: diff during shift=%h want %h", i, d1, prev_diff);
      end
      checks++;
      if (dn != 1 || {bout, diff} !== e) begin
        failures++;
        $display("FAIL values_result[%0d]: got dones=%0d bout=%b diff=%h want 1 %b %h",
                 i, dn, bout, diff, e[W], e[W-1:0]);
      end
      checks++;
      if (zero !== (e[W-1:0] == '0)) begin
        failures++;
        $display("FAIL values_zero[%0d]: got %b want %b", i, zero, (e[W-1:0] == '0));
      end
      prev_diff = e[W-1:0];
    end
  endtask

  task automatic test_ignore_start;
    int dn, bc;
    logic [W:0] e;
    start = 1'b1;
    a     = 8'h80;
    b     = 8'h01;
    exp_q.push_back(ref_sub(8'h80, 8'h01));
    @(posedge clk);
    #1;
    start = 1'b0;
    dn = 0;
    bc = 0;
    for (int c = 1; c <= W + 4; c++) begin
      @(negedge clk);
      if (busy) bc++;
      if (done) dn++;
      // Pulses land in SHIFT cycle 3 and in the DONE cycle.
      start = (c == 3 || c == W + 1);
      a     = 8'h00;
      b     = 8'h01;
    end
    start = 1'b0;
    e = exp_q.pop_front();
    checks++;
    if (dn != 1 || bc != W + 1) begin
      failures++;
      $display("FAIL ignore_done_count: got dones=%0d busy=%0d want 1 %0d", dn, bc, W + 1);
    end
    checks++;
    if ({bout, diff} !== e) begin
      failures++;
      $display("FAIL ignore_result: got bout=%b diff=%h want 0 7f", bout, diff);
    end
    begin
      int dc, dn2, bc2;
      logic [W-1:0] d1;
      do_op(8'h33, 8'h11, dc, dn2, bc2, d1);
      e = exp_q.pop_front();
      checks++;
      if (dn2 != 1 || dc != W + 1 || {bout, diff} !== e) begin
        failures++;
        $display("FAIL ignore_next_op: got dones=%0d cyc=%0d bout=%b diff=%h want 1 %0d 0 22",
                 dn2, dc, bout, diff, W + 1);
      end
    end
  endtask

  task automatic test_reset_mid;
    int dc, dn, bc;
    logic [W-1:0] d1;
    logic [W:0]   e;
    do_op(8'h5A, 8'h23, dc, dn, bc, d1);
    void'(exp_q.pop_front());
    checks++;
    if (diff !== 8'h37) begin
      failures++;
      $display("FAIL midrst_setup: diff=%h want 37", diff);
    end
    start = 1'b1;
    a     = 8'h44;
    b     = 8'h11;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (4) @(negedge clk);
    rst   = 1'b1;
    start = 1'b1;
    #1;
    checks++;
    if ({diff, bout, zero, busy, done} !== '0) begin
      failures++;
      $display("FAIL midrst_clear: got diff=%h bout=%b zero=%b busy=%b done=%b want all 0",
               diff, bout, zero, busy, done);
    end
    @(negedge clk);
    rst   = 1'b0;
    start = 1'b0;
    dn = 0;
    for (int c = 0; c < W + 3; c++) begin
      @(negedge clk);
      if (done || busy) dn++;
    end
    checks++;
    if (dn != 0) begin
      failures++;
      $display("FAIL midrst_no_done: got %0d busy/done cycles want 0", dn);
    end
    do_op(8'h03, 8'h05, dc, dn, bc, d1);
    e = exp_q.pop_front();
    checks++;
    if (dn != 1 || {bout, diff} !== e || e !== 9'h1FE) begin
      failures++;
      $display("FAIL midrst_next_op: got dones=%0d bout=%b diff=%h want 1 1 fe", dn, bout, diff);
    end
  endtask

  task automatic test_back_to_back;
    localparam int NOps = 1000;
    int since;
    int pushed;
    int dones;
    logic [W:0] e;
    since  = -1;
    dones  = 0;
    start  = 1'b1;
    a      = W'($urandom);
    b      = W'($urandom);
    exp_q.push_back(ref_sub(a, b));
    pushed = 1;
    for (int n = 0; n < NOps * (W + 2); n++) begin
      @(posedge clk);
      #1;
      since = (since == W + 1) ? 0 : since + 1;
      a = W'($urandom);
      b = W'($urandom);
      if (since == W + 1) begin
        if (pushed < NOps) begin
          exp_q.push_back(ref_sub(a, b));
          pushed++;
        end else begin
          start = 1'b0;
        end
      end
      @(negedge clk);
      if (done) begin
        dones++;
        e = (exp_q.size() > 0) ? exp_q.pop_front() : 'x;
        checks++;
        if (since != W || {bout, diff} !== e || zero !== (e[W-1:0] == '0)) begin
          failures++;
          $display("FAIL b2b_op[%0d]: got phase=%0d bout=%b diff=%h zero=%b want %0d %b %h",
                   dones, since, bout, diff, zero, W, e[W], e[W-1:0]);
        end
      end else if (since == W) begin
        checks++;
        failures++;
        $display("FAIL b2b_missing_done: op %0d got no done want done", dones);
      end
    end
    start = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (dones != NOps || exp_q.size() != 0 || busy !== 1'b0) begin
      failures++;
      $display("FAIL b2b_totals: got dones=%0d left=%0d busy=%b want %0d 0 0",
               dones, exp_q.size(), busy, NOps);
    end
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    start    = 1'b0;
    a        = '0;
    b        = '0;
    rst      = 1'b1;
    @(negedge clk);
    test_reset;
    test_basic;
    test_values;
    test_ignore_start;
    test_reset_mid;
    test_back_to_back;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Absolute time bound so the run always ends.
  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish within time limit");
    $fatal(1);
  end

endmodule
